// File: rtl/perf_counter_sampler_pkg.sv
// Shared types and constants for the performance-counter sampler.
// Holds the XLEN-wide data type used by the counter bank, the CSR
// addresses that bound the default sweep range, the FIFO sample record
// and the sampler FSM state encoding.
package perf_counter_sampler_pkg;

  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] xlen_t;

  // CSR addresses of the first and last counters in the default sweep.
  localparam logic [11:0] CSR_ML1_ICACHE_MISS = 12'hB03;
  localparam logic [11:0] CSR_MIF_EMPTY       = 12'hB10;

  // The counter bank is indexed by the low five bits of the CSR address.
  localparam logic [4:0] PERF_FIRST_ADDR = CSR_ML1_ICACHE_MISS[4:0];
  localparam logic [4:0] PERF_LAST_ADDR  = CSR_MIF_EMPTY[4:0];

  // One captured counter: its bank address and the value read from it.
  typedef struct packed {
    logic [4:0] addr;
    xlen_t      data;
  } perf_sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/perf_counter_sampler_fifo.sv
// Synchronous sample FIFO without fall-through.
// A pushed entry becomes visible at the head on the following cycle.
// A push into a full FIFO is accepted when a pop happens in the same
// cycle, because the pop frees the slot the push needs.
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, empties the FIFO
//   flush_i  synchronous flush, empties the FIFO
//   push_i   write data_i (ignored when full and not popping)
//   data_i   entry to write
//   full_o   all Depth entries occupied
//   empty_o  no entry present
//   pop_i    remove the head entry (ignored when empty)
//   data_o   head entry
module perf_counter_sampler_fifo #(
  parameter int unsigned DataWidth = 69,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 full_o,
  output logic                 empty_o,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AddrW:0]       count_q;
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/perf_counter_sampler.sv
// Performance-counter sampler.
// Sweeps counter addresses FirstAddr..LastAddr of the counter bank, either
// on a trigger pulse or when the idle timer expires, reading one counter
// per cycle and optionally clearing it with a write in the same cycle.
// Each read is queued as {addr, value} in a small FIFO toward a sink.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   enable_i           allow timer-started sweeps
//   period_i           idle cycles between sweeps, 0 disables the timer
//   trigger_i          one-cycle request for an immediate sweep
//   clear_on_read_i    zero each counter as it is read (latched per sweep)
//   pc_addr_o/pc_we_o/pc_wdata_o/pc_rdata_i  counter bank port
//   sample_valid_o/sample_ready_i/sample_addr_o/sample_data_o  sample stream
//   sweep_done_o       one-cycle pulse after the last address is captured
//   busy_o             a sweep is in progress
//   overflow_o         sticky: a sweep request arrived during a sweep
module perf_counter_sampler
  import perf_counter_sampler_pkg::*;
#(
  parameter logic [4:0]  FirstAddr = PERF_FIRST_ADDR,
  parameter logic [4:0]  LastAddr  = PERF_LAST_ADDR,
  parameter int unsigned FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  input  logic        trigger_i,
  input  logic        clear_on_read_i,
  output logic [4:0]  pc_addr_o,
  output logic        pc_we_o,
  output xlen_t       pc_wdata_o,
  input  xlen_t       pc_rdata_i,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic [4:0]  sample_addr_o,
  output xlen_t       sample_data_o,
  output logic        sweep_done_o,
  output logic        busy_o,
  output logic        overflow_o
);

  sweep_state_e state_q, state_d;
  logic [31:0]  timer_q, timer_d;
  logic [4:0]   ptr_q, ptr_d;
  logic         clear_q, clear_d;
  logic         done_q, done_d;
  logic         overflow_q, overflow_d;

  logic         timer_en, timer_hit, start_req;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop, can_push;
  logic         we_c;
  perf_sample_t push_sample, head_sample;

  assign timer_en  = enable_i && (period_i != 32'd0);
  assign timer_hit = timer_en && (timer_q == period_i - 32'd1);
  assign start_req = trigger_i || timer_hit;

  // The stall decision uses post-pop occupancy, so a full FIFO that is
  // being drained this cycle still accepts a read beat.
  assign fifo_pop = !fifo_empty && sample_ready_i;
  assign can_push = !fifo_full || fifo_pop;

  assign push_sample = '{addr: ptr_q, data: pc_rdata_i};

  // Next-state logic: the timer only runs in IDLE; a read beat happens in
  // every SWEEP cycle where the FIFO can take the sample.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ptr_d      = ptr_q;
    clear_d    = clear_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    pc_addr_o  = FirstAddr;
    we_c       = 1'b0;
    fifo_push  = 1'b0;
    if (state_q == IDLE) begin
      if (timer_en && (timer_q != '1)) timer_d = timer_q + 32'd1;
      if (start_req) begin
        state_d = SWEEP;
        timer_d = '0;
        ptr_d   = FirstAddr;
        clear_d = clear_on_read_i;
      end
    end else begin
      pc_addr_o = ptr_q;
      if (start_req) overflow_d = 1'b1;
      if (can_push) begin
        fifo_push = 1'b1;
        we_c      = clear_q;
        ptr_d     = ptr_q + 5'd1;
        if (ptr_q == LastAddr) begin
          state_d = IDLE;
          done_d  = 1'b1;
          timer_d = '0;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ptr_q      <= FirstAddr;
      clear_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ptr_q      <= ptr_d;
      clear_q    <= clear_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  perf_counter_sampler_fifo #(
    .DataWidth ($bits(perf_sample_t)),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_sample),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .pop_i   (fifo_pop),
    .data_o  (head_sample)
  );

  // A clearing write must never reach the bank while reset is asserted.
  assign pc_we_o    = we_c && !rst_i;
  assign pc_wdata_o = '0;

  // The head is masked to zero when empty so stale storage never shows.
  assign sample_valid_o = !fifo_empty;
  assign sample_addr_o  = fifo_empty ? 5'd0 : head_sample.addr;
  assign sample_data_o  = fifo_empty ? '0 : head_sample.data;

  assign sweep_done_o = done_q;
  assign busy_o       = (state_q == SWEEP);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Directed testbench for perf_counter_sampler with default parameters
// (sweep 3..16, four-entry FIFO) and a behavioural counter bank.
module tb_perf_counter_sampler;
  import perf_counter_sampler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic        trigger = 1'b0;
  logic        clearOnRead = 1'b0;
  logic [4:0]  pcAddr;
  logic        pcWe;
  xlen_t       pcWdata;
  xlen_t       pcRdata;
  logic        sampleValid;
  logic        sampleReady = 1'b1;
  logic [4:0]  sampleAddr;
  xlen_t       sampleData;
  logic        sweepDone;
  logic        busy;
  logic        overflow;
  logic        preload = 1'b0;

  xlen_t       bank [32];
  logic [4:0]  gotAddr [$];
  xlen_t       gotData [$];
  int          writeCount, doneCount, busyCycles;
  int          passCount = 0;
  int          checkCount = 0;

  always #5 clk = ~clk;

  perf_counter_sampler dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .period_i        (period),
    .trigger_i       (trigger),
    .clear_on_read_i (clearOnRead),
    .pc_addr_o       (pcAddr),
    .pc_we_o         (pcWe),
    .pc_wdata_o      (pcWdata),
    .pc_rdata_i      (pcRdata),
    .sample_valid_o  (sampleValid),
    .sample_ready_i  (sampleReady),
    .sample_addr_o   (sampleAddr),
    .sample_data_o   (sampleData),
    .sweep_done_o    (sweepDone),
    .busy_o          (busy),
    .overflow_o      (overflow)
  );

  // Counter bank: combinational read, write-after-read clears the counter.
  assign pcRdata = bank[pcAddr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) bank[i] <= 64'h100 + 64'(i);
    end else if (pcWe) begin
      bank[pcAddr] <= '0;
    end
  end

  // Records what the upcoming clock edge will do, then moves to the next
  // negative edge. Inputs are changed only between calls.
  task automatic stepCycle();
    #1;
    if (sampleValid && sampleReady) begin
      gotAddr.push_back(sampleAddr);
      gotData.push_back(sampleData);
    end
    if (pcWe) writeCount++;
    if (sweepDone) doneCount++;
    if (busy) busyCycles++;
    @(negedge clk);
  endtask

  task automatic clearRecords();
    gotAddr.delete();
    gotData.delete();
    writeCount = 0;
    doneCount  = 0;
    busyCycles = 0;
  endtask

  task automatic preloadBank();
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  task automatic pulseTrigger();
    trigger = 1'b1;
    stepCycle();
    trigger = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while ((busy || sampleValid) && n < budget) begin
      stepCycle();
      n++;
    end
    checkCount++;
    if (busy || sampleValid) $display("[TB] FAIL %s_timeout: still busy=%0b valid=%0b after %0d cycles, required idle", name, busy, sampleValid, n);
    else passCount++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({pcAddr, pcWe, sampleValid, sampleAddr, sweepDone, busy, overflow} !== {5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_ctrl: addr=%0d we=%0b valid=%0b saddr=%0d done=%0b busy=%0b ovf=%0b, required 3 0 0 0 0 0 0", pcAddr, pcWe, sampleValid, sampleAddr, sweepDone, busy, overflow);
    else passCount++;
    checkCount++;
    if (pcWdata !== 64'd0 || sampleData !== 64'd0) $display("[TB] FAIL reset_data: wdata=%0h sdata=%0h, required 0 0", pcWdata, sampleData);
    else passCount++;
    rst = 1'b0;
    stepCycle();
    checkCount++;
    if (busy !== 1'b0 || pcAddr !== 5'd3) $display("[TB] FAIL reset_idle: busy=%0b addr=%0d, required 0 3", busy, pcAddr);
    else passCount++;
  endtask

  task automatic test_basic_sweep();
    bit bad;
    preloadBank();
    clearRecords();
    sampleReady = 1'b1;
    clearOnRead = 1'b0;
    pulseTrigger();
    checkCount++;
    if (busy !== 1'b1 || pcAddr !== 5'd3) $display("[TB] FAIL basic_start: busy=%0b addr=%0d, required 1 3", busy, pcAddr);
    else passCount++;
    checkCount++;
    if (sampleValid !== 1'b0) $display("[TB] FAIL basic_no_fallthrough: valid=%0b, required 0", sampleValid);
    else passCount++;
    waitIdle(60, "basic");
    bad = (gotAddr.size() != 14);
    for (int i = 0; i < gotAddr.size() && !bad; i++)
      if (gotAddr[i] !== 5'(3 + i) || gotData[i] !== 64'h100 + 64'(3 + i)) bad = 1'b1;
    checkCount++;
    if (bad) $display("[TB] FAIL basic_samples: got %0d samples, required 14 of (a, 0x100+a) for a=3..16", gotAddr.size());
    else passCount++;
    checkCount++;
    if (doneCount !== 1 || busyCycles !== 14) $display("[TB] FAIL basic_done: done pulses=%0d busy cycles=%0d, required 1 14", doneCount, busyCycles);
    else passCount++;
    checkCount++;
    if (writeCount !== 0 || bank[3] !== 64'h103 || bank[16] !== 64'h110) $display("[TB] FAIL basic_unchanged: writes=%0d bank3=%0h bank16=%0h, required 0 103 110", writeCount, bank[3], bank[16]);
    else passCount++;
  endtask

  task automatic test_clear_on_read();
    bit bad;
    int zeroed;
    preloadBank();
    clearRecords();
    clearOnRead = 1'b1;
    pulseTrigger();
    clearOnRead = 1'b0;
    waitIdle(60, "clear");
    bad = (gotAddr.size() != 14);
    for (int i = 0; i < gotAddr.size() && !bad; i++)
      if (gotAddr[i] !== 5'(3 + i) || gotData[i] !== 64'h100 + 64'(3 + i)) bad = 1'b1;
    checkCount++;
    if (bad) $display("[TB] FAIL clear_samples: got %0d samples, required 14 of (a, 0x100+a)", gotAddr.size());
    else passCount++;
    zeroed = 0;
    for (int a = 3; a <= 16; a++) if (bank[a] === 64'd0) zeroed++;
    checkCount++;
    if (writeCount !== 14 || zeroed !== 14) $display("[TB] FAIL clear_writes: writes=%0d zeroed=%0d, required 14 14", writeCount, zeroed);
    else passCount++;
    checkCount++;
    if (bank[2] !== 64'h102 || bank[17] !== 64'h111) $display("[TB] FAIL clear_range: bank2=%0h bank17=%0h, required 102 111", bank[2], bank[17]);
    else passCount++;
    clearRecords();
    pulseTrigger();
    waitIdle(60, "clear_second");
    bad = (gotAddr.size() != 14);
    for (int i = 0; i < gotAddr.size() && !bad; i++)
      if (gotAddr[i] !== 5'(3 + i) || gotData[i] !== 64'd0) bad = 1'b1;
    checkCount++;
    if (bad || writeCount !== 0) $display("[TB] FAIL clear_second_sweep: samples=%0d writes=%0d, required 14 zero samples and 0 writes", gotAddr.size(), writeCount);
    else passCount++;
  endtask

  task automatic test_stall();
    bit bad;
    preloadBank();
    clearRecords();
    sampleReady = 1'b0;
    clearOnRead = 1'b1;
    pulseTrigger();
    clearOnRead = 1'b0;
    repeat (11) stepCycle();
    checkCount++;
    if (busy !== 1'b1 || pcAddr !== 5'd7 || pcWe !== 1'b0) $display("[TB] FAIL stall_hold: busy=%0b addr=%0d we=%0b, required 1 7 0", busy, pcAddr, pcWe);
    else passCount++;
    checkCount++;
    if (writeCount !== 4) $display("[TB] FAIL stall_beats: writes=%0d, required 4", writeCount);
    else passCount++;
    checkCount++;
    if (sampleValid !== 1'b1 || sampleAddr !== 5'd3 || sampleData !== 64'h103) $display("[TB] FAIL stall_head: valid=%0b addr=%0d data=%0h, required 1 3 103", sampleValid, sampleAddr, sampleData);
    else passCount++;
    sampleReady = 1'b1;
    #1;
    checkCount++;
    if (pcWe !== 1'b1 || pcAddr !== 5'd7) $display("[TB] FAIL stall_full_pop_push: we=%0b addr=%0d, required 1 7", pcWe, pcAddr);
    else passCount++;
    waitIdle(80, "stall");
    bad = (gotAddr.size() != 14);
    for (int i = 0; i < gotAddr.size() && !bad; i++)
      if (gotAddr[i] !== 5'(3 + i) || gotData[i] !== 64'h100 + 64'(3 + i)) bad = 1'b1;
    checkCount++;
    if (bad || writeCount !== 14 || doneCount !== 1) $display("[TB] FAIL stall_release: samples=%0d writes=%0d done=%0d, required 14 in order, 14, 1", gotAddr.size(), writeCount, doneCount);
    else passCount++;
  endtask

  task automatic test_timer();
    int n;
    clearRecords();
    sampleReady = 1'b1;
    period = 32'd40;
    enable = 1'b1;
    n = 0;
    while (!busy && n < 100) begin stepCycle(); n++; end
    checkCount++;
    if (n !== 40) $display("[TB] FAIL timer_first_start: started after %0d cycles, required 40", n);
    else passCount++;
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (!sweepDone && n < 60) begin stepCycle(); n++; end
      n = 0;
      while (!busy && n < 100) begin stepCycle(); n++; end
      checkCount++;
      if (n !== 40) $display("[TB] FAIL timer_restart_%0d: next sweep %0d cycles after done, required 40", s, n);
      else passCount++;
    end
    period = 32'd0;
    waitIdle(60, "timer");
    busyCycles = 0;
    repeat (100) stepCycle();
    checkCount++;
    if (busyCycles !== 0) $display("[TB] FAIL timer_period_zero: busy cycles=%0d, required 0", busyCycles);
    else passCount++;
    enable = 1'b0;
  endtask

  task automatic test_overflow();
    preloadBank();
    clearRecords();
    pulseTrigger();
    repeat (3) stepCycle();
    checkCount++;
    if (overflow !== 1'b0) $display("[TB] FAIL overflow_before: ovf=%0b, required 0", overflow);
    else passCount++;
    pulseTrigger();
    checkCount++;
    if (overflow !== 1'b1) $display("[TB] FAIL overflow_set: ovf=%0b, required 1", overflow);
    else passCount++;
    waitIdle(60, "overflow");
    repeat (20) stepCycle();
    checkCount++;
    if (doneCount !== 1 || gotAddr.size() !== 14 || overflow !== 1'b1) $display("[TB] FAIL overflow_single_sweep: done=%0d samples=%0d ovf=%0b, required 1 14 1", doneCount, gotAddr.size(), overflow);
    else passCount++;
  endtask

  task automatic test_reset_mid_sweep();
    preloadBank();
    clearRecords();
    clearOnRead = 1'b1;
    pulseTrigger();
    clearOnRead = 1'b0;
    repeat (4) stepCycle();
    checkCount++;
    if (pcAddr !== 5'd7 || pcWe !== 1'b1) $display("[TB] FAIL midrst_fifth_beat: addr=%0d we=%0b, required 7 1", pcAddr, pcWe);
    else passCount++;
    rst = 1'b1;
    stepCycle();
    checkCount++;
    if ({pcAddr, pcWe, sampleValid, sampleAddr, sweepDone, busy, overflow} !== {5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0} || sampleData !== 64'd0)
      $display("[TB] FAIL midrst_outputs: addr=%0d we=%0b valid=%0b saddr=%0d sdata=%0h done=%0b busy=%0b ovf=%0b, required reset values", pcAddr, pcWe, sampleValid, sampleAddr, sampleData, sweepDone, busy, overflow);
    else passCount++;
    rst = 1'b0;
    stepCycle();
    checkCount++;
    if (writeCount !== 4 || bank[6] !== 64'd0 || bank[7] !== 64'h107 || sampleValid !== 1'b0) $display("[TB] FAIL midrst_no_write: writes=%0d bank6=%0h bank7=%0h valid=%0b, required 4 0 107 0", writeCount, bank[6], bank[7], sampleValid);
    else passCount++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_sweep();
    test_clear_on_read();
    test_stall();
    test_timer();
    test_overflow();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
